row_reduce_accumulator: RTL and testbench
=========================================

Name: row_reduce_accumulator

Overview:
- Parametrised successor to the fixed eight-lane row organizer: reduces an NI-lane fp32 row through a registered adder tree.
- Accumulates successive rows into one scalar per vector; a vector ends on a row flagged row_last.
- Uses valid/ready handshakes with full-pipeline stall, replacing hand-built delay chains and free-running start control.
- Sits between the matrix/vector row feeders and the dot-product / conjugate-gradient update stages.

Parameters:
- NI, 8, lane count per row; power of two, 2..32.
- CNT_W, 16, width of the row and vector counters.
- LVL, log2(NI), tree depth; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  row_in and row_last are valid.
- in_ready  output  1  block accepts a row this cycle.
- row_in  input  NI*32  NI fp32 lanes; lane i is bits [32i+31:32i].
- row_last  input  1  this row closes the current vector.
- out_valid  output  1  sum_out holds a completed vector sum.
- out_ready  input  1  consumer takes sum_out.
- sum_out  output  32  fp32 sum of every lane of every row in the vector.
- row_count  output  CNT_W  rows accepted in the current vector.
- vec_count  output  CNT_W  completed vectors; wraps modulo 2^CNT_W.

Behaviour:
- Arithmetic:
  - Every add is IEEE-754 binary32, round-to-nearest-even, using the team's single-precision adder in add mode.
  - Tree level j pairs adjacent level j-1 results.
  - Addition order is fixed, so results are bit-reproducible.
- Stall:
  - en = !(out_valid && !out_ready).
  - in_ready = en.
  - A row is accepted when in_valid && in_ready.
  - When en=0, all tree, accumulator and counter registers hold.
- Pipeline:
  - LVL registered tree stages, each carrying a valid bit and a last bit, followed by one accumulator/output stage.
  - out_valid rises LVL+1 enabled cycles after the accepting edge.
  - Sustains one row per cycle when unstalled.
- Accumulator FSM: ACC_EMPTY, ACC_RUN.
  - ACC_EMPTY + valid tree result, last=0: acc <= tree result (no add with zero, so -0.0 is preserved); go to ACC_RUN.
  - ACC_EMPTY + valid, last=1: sum_out <= tree result; out_valid <= 1; stay in ACC_EMPTY.
  - ACC_RUN + valid, last=0: acc <= acc + tree result.
  - ACC_RUN + valid, last=1: sum_out <= acc + tree result; out_valid <= 1; go to ACC_EMPTY.
  - Bubbles (tree valid=0) leave state and acc unchanged.
- Output:
  - out_valid clears on out_ready unless a new sum loads in the same cycle; a new sum takes priority.
  - sum_out is stable while out_valid && !out_ready.
- Counters:
  - row_count increments on each accepted row and saturates at 2^CNT_W-1.
  - On an accepted row_last row, row_count resets to 0 and vec_count increments.
- Reset (rst_n=0 at a rising edge, including mid-vector):
  - All stage valids 0; FSM ACC_EMPTY; acc 0.
  - sum_out 0x00000000, out_valid 0, row_count 0, vec_count 0.
  - in_ready reads 1 from the first cycle after reset.
  - In-flight rows are discarded.

Optional Feature:
- Macro ROW_REDUCE_LEN_CHECK_EN.
- Defined:
  - Adds input vec_len [CNT_W-1:0] and output len_err (1 bit, sticky).
  - len_err sets when row_last is accepted with (row_count+1) != vec_len.
  - len_err also sets when a row is accepted with row_count+1 == vec_len but row_last=0.
  - Cleared only by reset.
  - Summation is unaffected.
- Undefined: neither port exists; no checking logic.

Test Plan:
- NI=8; one row, all lanes 0x3F800000 (1.0), row_last=1 -> out_valid 4 cycles later, sum_out=0x41000000 (8.0), vec_count=1.
- Four back-to-back rows of 1.0 lanes, last on the 4th -> single sum_out=0x42000000 (32.0); row_count 1,2,3 then 0.
- Two consecutive vectors (1 row of 2.0 lanes; 2 rows of 0.5 lanes) -> sums 0x41800000 (16.0) then 0x41000000 (8.0), no bubble.
- Back-pressure: out_ready=0 while the next vector's rows are in flight -> in_ready=0; sum_out held; both sums delivered in order once out_ready=1.
- rst_n low for one cycle mid-vector, after 2 of 4 rows -> all outputs 0; the following 1-row vector of 1.0 lanes returns 0x41000000.
- With ROW_REDUCE_LEN_CHECK_EN: vec_len=3, row_last on 2nd row -> len_err=1 and stays 1; sum still correct.

Source files
------------

// File: rtl/row_reduce_accumulator_if.sv
// row_reduce_accumulator_if: row-in / sum-out handshake bundle for row_reduce_accumulator.
// vec_len and len_err exist only when ROW_REDUCE_LEN_CHECK_EN is defined.
interface row_reduce_accumulator_if #(
    parameter int NI    = 8,
    parameter int CNT_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [NI*32-1:0]  row_in;
    logic              row_last;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       sum_out;
    logic [CNT_W-1:0]  row_count;
    logic [CNT_W-1:0]  vec_count;
`ifdef ROW_REDUCE_LEN_CHECK_EN
    logic [CNT_W-1:0]  vec_len;
    logic              len_err;
    modport master (
        output in_valid, row_in, row_last, out_ready, vec_len,
        input  in_ready, out_valid, sum_out, row_count, vec_count, len_err
    );
    modport slave (
        input  in_valid, row_in, row_last, out_ready, vec_len,
        output in_ready, out_valid, sum_out, row_count, vec_count, len_err
    );
`else
    modport master (
        output in_valid, row_in, row_last, out_ready,
        input  in_ready, out_valid, sum_out, row_count, vec_count
    );
    modport slave (
        input  in_valid, row_in, row_last, out_ready,
        output in_ready, out_valid, sum_out, row_count, vec_count
    );
`endif
endinterface

// File: rtl/row_reduce_accumulator.sv
// row_reduce_accumulator: NI-lane fp32 row sum via registered adder tree, accumulated per vector.
// Optional vector-length checking is enabled by defining ROW_REDUCE_LEN_CHECK_EN.
module row_reduce_accumulator #(
    parameter int NI    = 8,
    parameter int CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    row_reduce_accumulator_if.slave   bus
);
    localparam int LVL = $clog2(NI);

    typedef enum logic {ACC_EMPTY, ACC_RUN} acc_state_t;

    // binary32 add, round-to-nearest-even, one guard/round/sticky triple
    function automatic logic [31:0] fp_add(input logic [31:0] a_in, input logic [31:0] b_in);
        logic [31:0] a, b;
        logic [7:0]  ea, eb, d8;
        logic [9:0]  e;
        logic [23:0] ma, mb;
        logic [26:0] xa, xb, xs, mask;
        logic [27:0] s;
        logic [24:0] rnd;
        logic        sub, up;
        {a, b} = (a_in[30:0] >= b_in[30:0]) ? {a_in, b_in} : {b_in, a_in};
        if (a[30:23] == 8'hFF)
            return (a[22:0] != 23'd0 || (b[30:0] == a[30:0] && a[31] != b[31])) ? 32'h7FC00000 : a;
        sub  = a[31] ^ b[31];
        ea   = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
        eb   = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
        ma   = {a[30:23] != 8'd0, a[22:0]};
        mb   = {b[30:23] != 8'd0, b[22:0]};
        d8   = ea - eb;
        xa   = {ma, 3'b000};
        xb   = {mb, 3'b000};
        mask = (27'd1 << d8) - 27'd1;
        xs   = (d8 > 8'd26) ? {26'd0, |mb} : ((xb >> d8) | {26'd0, |(xb & mask)});
        s    = sub ? ({1'b0, xa} - {1'b0, xs}) : ({1'b0, xa} + {1'b0, xs});
        if (s == 28'd0)
            return {a[31] & b[31], 31'd0};
        e = {2'b00, ea};
        if (s[27]) begin
            s = {1'b0, s[27:1]} | {27'd0, s[0]};
            e = e + 10'd1;
        end
        for (int i = 0; i < 26; i++)
            if (!s[26] && e > 10'd1) begin
                s = s << 1;
                e = e - 10'd1;
            end
        up  = s[2] && (s[1] || s[0] || s[3]);
        rnd = {1'b0, s[26:3]} + {24'd0, up};
        if (rnd[24]) begin
            rnd = rnd >> 1;
            e   = e + 10'd1;
        end
        if (e >= 10'd255)
            return {a[31], 8'hFF, 23'd0};
        return {a[31], rnd[23] ? e[7:0] : 8'd0, rnd[22:0]};
    endfunction

    logic              w_en, w_take, w_tv, w_tl;
    logic [31:0]       w_node [2*NI-2:0];
    logic [31:0]       w_tree, w_add, w_res;
    logic [LVL-1:0]    r_v, r_l;
    acc_state_t        r_state, w_state_nxt;
    logic [31:0]       r_acc, w_acc_nxt, r_sum, w_sum_nxt;
    logic              r_ov, w_ov_nxt;
    logic [CNT_W-1:0]  r_rows, w_rows_nxt, r_vecs, w_vecs_nxt;

    assign w_en   = !(r_ov && !bus.out_ready);
    assign w_take = bus.in_valid && w_en;

    // w_node holds the tree heap: leaves first, then each level's registered sums
    for (genvar i = 0; i < NI; i++) begin : g_leaf
        assign w_node[i] = bus.row_in[32*i +: 32];
    end

    for (genvar j = 1; j <= LVL; j++) begin : g_lvl
        for (genvar k = 0; k < (NI >> j); k++) begin : g_add
            logic [31:0] r_sum_n;
            always_ff @(posedge clk)
                if (w_en)
                    r_sum_n <= fp_add(w_node[2*NI - 2*(NI >> (j-1)) + 2*k],
                                      w_node[2*NI - 2*(NI >> (j-1)) + 2*k + 1]);
            assign w_node[2*NI - 2*(NI >> j) + k] = r_sum_n;
        end
    end

    assign w_tv   = r_v[LVL-1];
    assign w_tl   = r_l[LVL-1];
    assign w_tree = w_node[2*NI-2];
    assign w_add  = fp_add(r_acc, w_tree);
    // first row of a vector loads unchanged so a lone -0.0 survives
    assign w_res  = (r_state == ACC_RUN) ? w_add : w_tree;

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_sum_nxt   = r_sum;
        w_ov_nxt    = r_ov && !bus.out_ready;
        if (w_en && w_tv) begin
            w_state_nxt = w_tl ? ACC_EMPTY : ACC_RUN;
            if (w_tl) begin
                w_sum_nxt = w_res;
                w_ov_nxt  = 1'b1;
            end else
                w_acc_nxt = w_res;
        end
    end

    assign w_rows_nxt = !w_take ? r_rows : bus.row_last ? '0 : (&r_rows) ? r_rows : r_rows + CNT_W'(1);
    assign w_vecs_nxt = (w_take && bus.row_last) ? r_vecs + CNT_W'(1) : r_vecs;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v     <= '0;
            r_l     <= '0;
            r_state <= ACC_EMPTY;
            r_acc   <= '0;
            r_sum   <= '0;
            r_ov    <= 1'b0;
            r_rows  <= '0;
            r_vecs  <= '0;
        end else begin
            if (w_en) begin
                r_v <= LVL'({r_v, w_take});
                r_l <= LVL'({r_l, bus.row_last});
            end
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_sum   <= w_sum_nxt;
            r_ov    <= w_ov_nxt;
            r_rows  <= w_rows_nxt;
            r_vecs  <= w_vecs_nxt;
        end
    end

    assign bus.in_ready  = w_en;
    assign bus.out_valid = r_ov;
    assign bus.sum_out   = r_sum;
    assign bus.row_count = r_rows;
    assign bus.vec_count = r_vecs;

`ifdef ROW_REDUCE_LEN_CHECK_EN
    logic             r_len_err;
    logic [CNT_W:0]   w_rc1;
    assign w_rc1 = {1'b0, r_rows} + {{CNT_W{1'b0}}, 1'b1};
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_len_err <= 1'b0;
        else if (w_take && (bus.row_last ? (w_rc1 != {1'b0, bus.vec_len}) : (w_rc1 == {1'b0, bus.vec_len})))
            r_len_err <= 1'b1;
    end
    assign bus.len_err = r_len_err;
`endif
endmodule

// File: tb/tb_row_reduce_accumulator.sv
// tb_row_reduce_accumulator: directed checks of row_reduce_accumulator with NI=8.
module tb_row_reduce_accumulator;
    localparam int NI    = 8;
    localparam int CNT_W = 16;
    localparam logic [31:0] ONE  = 32'h3F800000;
    localparam logic [31:0] TWO  = 32'h40000000;
    localparam logic [31:0] HALF = 32'h3F000000;
    localparam logic [31:0] NZ   = 32'h80000000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [NI*32-1:0] row_mix, row_rnd;
    logic [31:0] mix [NI] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                              32'hBFC00000, 32'h3F000000, 32'h41200000, 32'hBE800000};

    always #5 clk = ~clk;

    row_reduce_accumulator_if #(.NI(NI), .CNT_W(CNT_W)) bus ();
    row_reduce_accumulator #(.NI(NI), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [NI*32-1:0] fill(input logic [31:0] v);
        return {NI{v}};
    endfunction

    task automatic send_row(input logic [NI*32-1:0] row, input logic last);
        bus.in_valid = 1'b1;
        bus.row_in   = row;
        bus.row_last = last;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_ov(input string tag);
        for (int i = 0; i < 20 && bus.out_valid !== 1'b1; i++)
            @(negedge clk);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            row_mix[32*i +: 32] = mix[i];
            row_rnd[32*i +: 32] = (i % 2 == 0) ? ONE : 32'h33800000;
        end
        bus.in_valid  = 1'b0;
        bus.row_in    = '0;
        bus.row_last  = 1'b0;
        bus.out_ready = 1'b1;
`ifdef ROW_REDUCE_LEN_CHECK_EN
        bus.vec_len   = 16'd1;
`endif
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum", bus.sum_out, 32'd0);
        chk("rst_rows", 32'(bus.row_count), 32'd0);
        chk("rst_vecs", 32'(bus.vec_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        send_row(fill(ONE), 1'b1);
        chk("t1_rows", 32'(bus.row_count), 32'd0);
        chk("t1_vecs", 32'(bus.vec_count), 32'd1);
        repeat (2) @(negedge clk);
        chk("t1_early", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("t1_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_sum", bus.sum_out, 32'h41000000);
        @(negedge clk);
        chk("t1_clear", 32'(bus.out_valid), 32'd0);

        for (int i = 1; i <= 4; i++) begin
            send_row(fill(ONE), i == 4);
            chk($sformatf("t2_rows%0d", i), 32'(bus.row_count), (i == 4) ? 32'd0 : 32'(i));
        end
        wait_ov("t2");
        chk("t2_sum", bus.sum_out, 32'h42000000);
        chk("t2_vecs", 32'(bus.vec_count), 32'd2);
        @(negedge clk);
        chk("t2_single", 32'(bus.out_valid), 32'd0);

        send_row(fill(TWO), 1'b1);
        send_row(fill(HALF), 1'b0);
        send_row(fill(HALF), 1'b1);
        wait_ov("t3a");
        chk("t3a_sum", bus.sum_out, 32'h41800000);
        @(negedge clk);
        chk("t3_gap", 32'(bus.out_valid), 32'd0);
        wait_ov("t3b");
        chk("t3b_sum", bus.sum_out, 32'h41000000);
        chk("t3_vecs", 32'(bus.vec_count), 32'd4);
        @(negedge clk);

        bus.out_ready = 1'b0;
        send_row(fill(ONE), 1'b1);
        send_row(fill(TWO), 1'b1);
        wait_ov("t4a");
        chk("t4a_sum", bus.sum_out, 32'h41000000);
        chk("t4_stall_ready", 32'(bus.in_ready), 32'd0);
        repeat (3) @(negedge clk);
        chk("t4_hold_valid", 32'(bus.out_valid), 32'd1);
        chk("t4_hold_sum", bus.sum_out, 32'h41000000);
        chk("t4_hold_ready", 32'(bus.in_ready), 32'd0);
        chk("t4_vecs", 32'(bus.vec_count), 32'd6);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t4b_valid", 32'(bus.out_valid), 32'd1);
        chk("t4b_sum", bus.sum_out, 32'h41800000);
        @(negedge clk);
        chk("t4_drain", 32'(bus.out_valid), 32'd0);

        send_row(row_mix, 1'b1);
        wait_ov("mix");
        chk("mix_sum", bus.sum_out, 32'h41960000);
        @(negedge clk);

        send_row(row_rnd, 1'b1);
        wait_ov("rne");
        chk("rne_sum", bus.sum_out, 32'h40800000);
        @(negedge clk);

        send_row(fill(NZ), 1'b0);
        send_row(fill(NZ), 1'b1);
        wait_ov("negzero");
        chk("negzero_sum", bus.sum_out, NZ);
        chk("negzero_vecs", 32'(bus.vec_count), 32'd9);
        @(negedge clk);

        for (int i = 0; i < 65535; i++)
            send_row(fill(ONE), 1'b0);
        chk("sat_max", 32'(bus.row_count), 32'h0000FFFF);
        send_row(fill(ONE), 1'b0);
        chk("sat_hold", 32'(bus.row_count), 32'h0000FFFF);

        send_row(fill(ONE), 1'b0);
        send_row(fill(ONE), 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_sum", bus.sum_out, 32'd0);
        chk("t5_rows", 32'(bus.row_count), 32'd0);
        chk("t5_vecs", 32'(bus.vec_count), 32'd0);
        rst_n = 1'b1;
        chk("t5_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (5) @(negedge clk);
        chk("t5_discard", 32'(bus.out_valid), 32'd0);
        send_row(fill(ONE), 1'b1);
        wait_ov("t5_after");
        chk("t5_after_sum", bus.sum_out, 32'h41000000);
        chk("t5_after_vecs", 32'(bus.vec_count), 32'd1);
        @(negedge clk);

`ifdef ROW_REDUCE_LEN_CHECK_EN
        chk("len_ok", 32'(bus.len_err), 32'd0);
        bus.vec_len = 16'd3;
        send_row(fill(ONE), 1'b0);
        send_row(fill(ONE), 1'b1);
        chk("len_set", 32'(bus.len_err), 32'd1);
        wait_ov("len");
        chk("len_sum", bus.sum_out, 32'h41800000);
        repeat (3) @(negedge clk);
        chk("len_sticky", 32'(bus.len_err), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
